// File: rtl/dual_rail_tx_pkg.sv
// dual_rail_tx_pkg: shared FSM state type and default sizing for the dual-rail transmitter
package dual_rail_tx_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_GAP_LEN = 4;
endpackage

// File: rtl/dual_rail_tx_pulse_timer.sv
// pulse_timer: loadable down-counter, expired while the count sits at zero
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= len;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/dual_rail_tx.sv
// dual_rail_tx: serialises words MSB first as return-to-zero pulses on a positive/negative rail pair
module dual_rail_tx
  import dual_rail_tx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_p,
  output logic              out_n,
  output logic              busy,
  output logic              tx_done
);
  localparam int MAXL = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
  localparam int CW = $clog2(MAXL + 1);
  localparam int BW = $clog2(DATA_W + 1);
  if (DATA_W < 1 || PULSE_LEN < 1 || GAP_LEN < 4) begin : g_param_check
    $error("dual_rail_tx: need DATA_W>=1, PULSE_LEN>=1, GAP_LEN>=4");
  end
  state_t            state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt, sh;
  logic [BW-1:0]     bcnt, bcnt_nxt;
  logic [CW-1:0]     len;
  logic              load, expired, p_nxt, n_nxt, done_nxt;
  pulse_timer #(.W(CW)) u_timer (
    .clk(clk), .rst(rst), .load(load), .len(len), .expired(expired)
  );
  assign sh = sr << 1;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    sr_nxt = sr;
    bcnt_nxt = bcnt;
    load = 1'b0;
    len = '0;
    p_nxt = 1'b0;
    n_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE:
        if (in_valid) begin
          state_nxt = PULSE;
          load = 1'b1;
          len = CW'(PULSE_LEN - 1);
          sr_nxt = in_data;
          bcnt_nxt = '0;
          p_nxt = in_data[DATA_W-1];
          n_nxt = ~in_data[DATA_W-1];
        end
      PULSE:
        if (expired) begin
          state_nxt = GAP;
          load = 1'b1;
          len = CW'(GAP_LEN - 1);
        end else begin
          p_nxt = out_p;
          n_nxt = out_n;
        end
      GAP:
        if (expired) begin
          load = 1'b1;
          if (bcnt == BW'(DATA_W - 1)) begin
            state_nxt = IDLE;
            done_nxt = 1'b1;
          end else begin
            state_nxt = PULSE;
            len = CW'(PULSE_LEN - 1);
            sr_nxt = sh;
            bcnt_nxt = bcnt + 1'b1;
            p_nxt = sh[DATA_W-1];
            n_nxt = ~sh[DATA_W-1];
          end
        end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sr <= '0;
      bcnt <= '0;
      out_p <= 1'b0;
      out_n <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_nxt;
      sr <= sr_nxt;
      bcnt <= bcnt_nxt;
      out_p <= p_nxt;
      out_n <= n_nxt;
      tx_done <= done_nxt;
    end
endmodule

// File: tb/tb_dual_rail_tx.sv
// tb_dual_rail_tx: cycle-level expectation queue plus OR-filter loopback receiver around dual_rail_tx
module tb_dual_rail_tx;
  localparam int W = 8, P = 4, G = 4;
  localparam logic [4:0] IDLE_V = 5'b00010;
  logic clk = 0, rst = 0, in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_p, out_n, busy, tx_done;
  int total = 0, bad = 0, rx_cnt = 0;
  logic [4:0] q[$];
  bit tx_bits[$];
  logic [4:0] cur_v, exp_v;
  logic [2:0] hp = '0, hn = '0;
  logic fp, fn, fp_prev = 0, fn_prev = 0;

  dual_rail_tx #(.DATA_W(W), .PULSE_LEN(P), .GAP_LEN(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_p(out_p), .out_n(out_n), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected {p,n,busy,ready,done} per cycle: each accepted word expands into its full waveform
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      tx_bits.delete();
    end else begin
      cur_v = q.size() > 0 ? q.pop_front() : IDLE_V;
      if (cur_v[1] && in_valid) begin
        for (int i = W - 1; i >= 0; i--) begin
          tx_bits.push_back(in_data[i]);
          repeat (P) q.push_back({in_data[i], ~in_data[i], 3'b100});
          repeat (G) q.push_back(5'b00100);
        end
        q.push_back(5'b00011);
      end
    end
    #1;
    exp_v = q.size() > 0 ? q[0] : IDLE_V;
    chk("cycle", {27'd0, out_p, out_n, busy, in_ready, tx_done}, {27'd0, exp_v});
    chk("rails_excl", {31'd0, out_p & out_n}, 0);
  end

  task automatic rx(input bit b);
    chk("rx_avail", {31'd0, tx_bits.size() > 0}, 1);
    if (tx_bits.size() > 0) chk("rx_bit", {31'd0, b}, {31'd0, tx_bits.pop_front()});
    rx_cnt++;
  endtask

  always @(posedge clk) begin
    #3;
    if (!rst) begin
      hp = '0; hn = '0; fp_prev = 0; fn_prev = 0;
    end else begin
      fp = out_p | (|hp);
      fn = out_n | (|hn);
      if (fp && !fp_prev) rx(1'b1);
      if (fn && !fn_prev) rx(1'b0);
      hp = {hp[1:0], out_p};
      hn = {hn[1:0], out_n};
      fp_prev = fp;
      fn_prev = fn;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("idle_wait", {31'd0, in_ready}, 1);
  endtask

  task automatic send_collect(input logic [7:0] w, input bit tog, output logic [7:0] bits);
    wait_idle();
    in_valid = 1;
    in_data = w;
    bits = '0;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      in_valid = tog && c < 64;
      if (tog) in_data = 8'($urandom);
      if ((c - 1) % 8 == 0 && c <= 64) begin
        bits[7 - (c - 1) / 8] = out_p;
        chk("pulse_pair", {31'd0, out_p ^ out_n}, 1);
      end
      if (c >= 64) chk($sformatf("done_c%0d", c), {31'd0, tx_done}, {31'd0, c == 65});
    end
  endtask

  initial begin
    logic [7:0] bits, w;
    int acc[2];
    int n;
    repeat (3) @(negedge clk);
    chk("rst_outs", {28'd0, out_p, out_n, busy, tx_done}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    rst = 1;
    repeat (20) @(negedge clk);
    send_collect(8'hA5, 0, bits);
    chk("a5_bits", {24'd0, bits}, 32'hA5);
    w = 8'($urandom);
    send_collect(w, 1, bits);
    chk("toggle_bits", {24'd0, bits}, {24'd0, w});
    wait_idle();
    in_valid = 1;
    in_data = 8'hFF;
    n = 0;
    for (int c = 0; c < 300 && n < 2; c++) begin
      if (in_ready) begin
        acc[n] = c;
        n++;
        if (n == 1) in_data = 8'h00;
      end
      @(negedge clk);
    end
    in_valid = 0;
    chk("accept_cnt", n, 2);
    chk("accept_gap", acc[1] - acc[0], 65);
    wait_idle();
    in_valid = 1;
    in_data = 8'h3C;
    @(negedge clk);
    in_valid = 0;
    repeat (25) @(negedge clk);
    chk("b3_high", {31'd0, out_p}, 1);
    rst = 0;
    #1;
    chk("abort_outs", {28'd0, out_p, out_n, busy, tx_done}, 0);
    chk("abort_ready", {31'd0, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    send_collect(8'h81, 0, bits);
    chk("after_rst_bits", {24'd0, bits}, 32'h81);
    repeat (2000) begin
      @(negedge clk);
      in_valid = ($urandom % 3) != 0;
      in_data = 8'($urandom);
    end
    in_valid = 0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("rx_drained", tx_bits.size(), 0);
    chk("rx_volume", {31'd0, rx_cnt > 200}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
